// File: rtl/seq_alu.sv
// Registered N-bit ALU with valid/ready handshakes. Multiply and divide iterate
// one bit per cycle through a shared {hi,lo} working pair; other ops take one cycle.
module seq_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] val1,
  input  logic [N-1:0] val2,
  input  logic [3:0]   select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] ext,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_dz
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, nstate;

  logic [N-1:0]  hi, lo, opb;
  logic [CW-1:0] cnt;

  // single-cycle datapath
  logic [SW-1:0]  k;
  logic [N:0]     add_w, sub_w, shl_w, shr_w;
  logic [2*N-1:0] dbl, rol_w, ror_w;
  logic [N-1:0]   c_res, c_ext;
  logic           c_c, c_v, c_dz;
  logic           go_mul, go_div;

  always_comb begin
    k     = val2[SW-1:0];
    add_w = {1'b0, val1} + {1'b0, val2};
    sub_w = {1'b0, val1} - {1'b0, val2};
    shl_w = {1'b0, val1} << k;
    // bit 0 of shr_w is the last bit shifted out
    shr_w = {val1, 1'b0} >> k;
    dbl   = {val1, val1};
    rol_w = dbl >> (N - int'(k));
    ror_w = dbl >> k;
    c_res = '0;
    c_ext = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_dz  = 1'b0;
    case (select)
      4'h0: begin
        c_res = add_w[N-1:0];
        c_c   = add_w[N];
        c_v   = (val1[N-1] == val2[N-1]) && (add_w[N-1] != val1[N-1]);
      end
      4'h1: begin
        c_res = sub_w[N-1:0];
        c_c   = sub_w[N];
        c_v   = (val1[N-1] != val2[N-1]) && (sub_w[N-1] != val1[N-1]);
      end
      4'h3: begin
        c_ext = val1;
        c_dz  = 1'b1;
      end
      4'h4: begin
        c_res = shl_w[N-1:0];
        c_c   = shl_w[N];
      end
      4'h5: begin
        c_res = shr_w[N:1];
        c_c   = shr_w[0];
      end
      4'h6: c_res = rol_w[N-1:0];
      4'h7: c_res = ror_w[N-1:0];
      4'h8: c_res = val1 & val2;
      4'h9: c_res = val1 | val2;
      4'hA: c_res = val1 ^ val2;
      4'hB: c_res = ~(val1 | val2);
      4'hC: c_res = ~(val1 & val2);
      4'hD: c_res = ~(val1 ^ val2);
      4'hE: c_res = {{(N-1){1'b0}}, val1 > val2};
      4'hF: c_res = {{(N-1){1'b0}}, val1 == val2};
      default: c_res = '0;
    endcase
  end

  assign go_mul = (select == 4'h2);
  assign go_div = (select == 4'h3) && (val2 != '0);

  // iteration step: shift-add multiply or restoring divide
  logic [N:0]   m_sum, d_sh, d_rem;
  logic         d_ge;
  logic [N-1:0] nhi, nlo;

  always_comb begin
    m_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    d_sh  = {hi, lo[N-1]};
    d_ge  = (d_sh >= {1'b0, opb});
    d_rem = d_ge ? (d_sh - {1'b0, opb}) : d_sh;
    if (state == DIV) begin
      nhi = d_rem[N-1:0];
      nlo = {lo[N-2:0], d_ge};
    end else begin
      nhi = m_sum[N:1];
      nlo = {m_sum[0], lo[N-1:1]};
    end
  end

  logic         last_it, ld;
  logic [N-1:0] ld_res, ld_ext;
  logic         ld_c, ld_v, ld_dz;

  always_comb begin
    last_it = ((state == MUL) || (state == DIV)) && (cnt == CW'(1));
    ld      = last_it || ((state == IDLE) && in_valid && !go_mul && !go_div);
    ld_res  = last_it ? nlo : c_res;
    ld_ext  = last_it ? nhi : c_ext;
    ld_c    = last_it ? ((state == MUL) && (nhi != '0)) : c_c;
    ld_v    = last_it ? 1'b0 : c_v;
    ld_dz   = last_it ? 1'b0 : c_dz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (in_valid) nstate = go_mul ? MUL : (go_div ? DIV : DONE);
      MUL, DIV: if (cnt == CW'(1)) nstate = DONE;
      DONE: if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; opb <= '0; cnt <= '0;
      result <= '0; ext <= '0;
      flag_c <= 1'b0; flag_v <= 1'b0; flag_z <= 1'b0; flag_n <= 1'b0; flag_dz <= 1'b0;
    end else begin
      if ((state == IDLE) && in_valid && (go_mul || go_div)) begin
        hi  <= '0;
        lo  <= val1;
        opb <= val2;
        cnt <= CW'(N);
      end else if ((state == MUL) || (state == DIV)) begin
        hi  <= nhi;
        lo  <= nlo;
        cnt <= cnt - CW'(1);
      end
      if (ld) begin
        result  <= ld_res;
        ext     <= ld_ext;
        flag_c  <= ld_c;
        flag_v  <= ld_v;
        flag_z  <= (ld_res == '0);
        flag_n  <= ld_res[N-1];
        flag_dz <= ld_dz;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8): hand-computed results, flags, latency,
// backpressure hold and asynchronous reset mid-multiply.
module tb_seq_alu;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [N-1:0] val1 = '0, val2 = '0;
  logic [3:0]   select = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [N-1:0] result, ext;
  logic         flag_c, flag_v, flag_z, flag_n, flag_dz;
  logic [4:0]   flg;

  int checks = 0;
  int failures = 0;
  int lat;
  logic irbad;

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .val1(val1), .val2(val2), .select(select), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ext(ext), .flag_c(flag_c),
    .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;
  // {c, v, z, n, dz}
  assign flg = {flag_c, flag_v, flag_z, flag_n, flag_dz};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    select = op; val1 = a; val2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    val1 = N'($urandom); val2 = N'($urandom); select = 4'($urandom);
  endtask

  // lat = index of the edge after which out_valid is first seen (accept edge = 0)
  task automatic do_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    issue(op, a, b);
    lat = 0;
    irbad = in_ready;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      irbad = irbad | in_ready;
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] r, input logic [N-1:0] e,
                            input logic [4:0] f);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".ext"}, 32'(ext), 32'(e));
    chk({tag, ".flags"}, 32'(flg), 32'(f));
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    expect_out("rst", 8'h00, 8'h00, 5'b00000);
    @(negedge clk); rst_n = 1'b1;

    // 1: add
    do_op(4'h0, 8'd200, 8'd100);
    chk("add1.lat", 32'(lat), 32'd0);
    expect_out("add1", 8'd44, 8'd0, 5'b10000);
    consume();
    do_op(4'h0, 8'd100, 8'd100);
    expect_out("add2", 8'd200, 8'd0, 5'b01010);
    consume();

    // 2: sub, equal, xor
    do_op(4'h1, 8'd5, 8'd10);
    expect_out("sub", 8'd251, 8'd0, 5'b10010);
    consume();
    do_op(4'hF, 8'd7, 8'd7);
    expect_out("eq", 8'd1, 8'd0, 5'b00000);
    consume();
    do_op(4'hA, 8'h5A, 8'h5A);
    expect_out("xor", 8'd0, 8'd0, 5'b00100);
    consume();

    // 3: mul, div, div by zero
    do_op(4'h2, 8'd200, 8'd3);
    chk("mul.lat", 32'(lat), 32'd8);
    chk("mul.in_ready_low", 32'(irbad), 32'd0);
    expect_out("mul", 8'h58, 8'h02, 5'b10000);
    consume();
    do_op(4'h3, 8'd100, 8'd7);
    chk("div.lat", 32'(lat), 32'd8);
    expect_out("div", 8'd14, 8'd2, 5'b00000);
    consume();
    do_op(4'h3, 8'd100, 8'd0);
    chk("div0.lat", 32'(lat), 32'd0);
    expect_out("div0", 8'd0, 8'd100, 5'b00101);
    consume();

    // 4: shifts / rotates and a few more single-cycle ops
    do_op(4'h6, 8'h81, 8'd3);
    expect_out("rol", 8'h0C, 8'h00, 5'b00000);
    consume();
    do_op(4'h4, 8'h81, 8'd1);
    expect_out("shl", 8'h02, 8'h00, 5'b10000);
    consume();
    do_op(4'h5, 8'h03, 8'd0);
    expect_out("shr0", 8'h03, 8'h00, 5'b00000);
    consume();
    do_op(4'h5, 8'h81, 8'd1);
    expect_out("shr1", 8'h40, 8'h00, 5'b10000);
    consume();
    do_op(4'h7, 8'h81, 8'd1);
    expect_out("ror", 8'hC0, 8'h00, 5'b00010);
    consume();
    do_op(4'hE, 8'd9, 8'd3);
    expect_out("gt", 8'd1, 8'd0, 5'b00000);
    consume();
    do_op(4'hB, 8'h00, 8'h00);
    expect_out("nor", 8'hFF, 8'd0, 5'b00010);
    consume();

    // 5: backpressure on a finished mul (15*17 = 255)
    do_op(4'h2, 8'd15, 8'd17);
    chk("bp.lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      select = 4'h0; val1 = 8'd1; val2 = 8'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      expect_out("bp.hold", 8'hFF, 8'h00, 5'b00010);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.release.in_ready", 32'(in_ready), 32'd1);
    chk("bp.release.out_valid", 32'(out_valid), 32'd0);
    do_op(4'h0, 8'd3, 8'd4);
    chk("bp.next.lat", 32'(lat), 32'd0);
    expect_out("bp.next", 8'd7, 8'd0, 5'b00000);
    consume();

    // 6: async reset during mul iteration 4
    issue(4'h2, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    expect_out("rstmid", 8'h00, 8'h00, 5'b00000);
    repeat (2) @(posedge clk);
    #1 chk("rstmid.hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.no_valid", 32'(out_valid), 32'd0);
    do_op(4'h0, 8'd1, 8'd1);
    chk("post_rst.lat", 32'(lat), 32'd0);
    expect_out("post_rst", 8'd2, 8'd0, 5'b00000);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
